rcas_acc_32bit: RTL and testbench
=================================

# rcas_acc_32bit

Sequential accumulator stage wrapped around the 32-bit ripple-carry adder/subtractor. It accepts one command per handshake (LOAD, ADD, SUB or CLEAR) with a 32-bit operand. It applies the command to an internal accumulator by driving `rcas_32bit` with a = accumulator, b = operand and sel = subtract. It returns the new accumulator value and flags on a valid/ready output port, and is the first registered consumer of the combinational adder/subtractor.

## Interface
- `ACC_INIT`, default 32'h0000_0000: accumulator value after reset.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: command valid.
- `in_ready` output 1: block can accept a command.
- `op` input 2: command. 2'b00 LOAD, 2'b01 ADD, 2'b10 SUB, 2'b11 CLEAR.
- `operand` input 32: operand; ignored for CLEAR.
- `out_valid` output 1: response valid.
- `out_ready` input 1: downstream accepts the response.
- `acc` output 32: accumulator register, visible at all times.
- `c_out` output 1: carry out of the last ADD/SUB. For SUB, 1 means no borrow.
- `ovf` output 1: signed overflow of the last ADD/SUB.
- `zero` output 1: accumulator == 0 after the last command.
- `ovf_sticky` output 1: OR of `ovf` since the last CLEAR or reset.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - `in_ready` = 1 (gated by `rst_n`; it is 0 during any cycle in which `rst_n` = 0).
  - On `in_valid && in_ready`, latch `op` and `operand` into internal registers, then go to EXEC.
- **EXEC** (exactly one cycle)
  - The adder sees a = `acc` and b = latched operand. Its sel and c_in are 1 only for SUB.
  - At the clock edge, update `acc` and the flags, then go to RESP.
- **RESP**
  - `out_valid` = 1. `acc` and the flags are held stable.
  - On `out_ready`, go to IDLE.
- Accumulator updates per command:
  - LOAD: acc ← operand.
  - ADD: acc ← acc + operand.
  - SUB: acc ← acc − operand.
  - CLEAR: acc ← 0 (not ACC_INIT).
- Arithmetic is 32-bit modulo 2^32.
- `c_out` is bit 32 of the adder. On SUB, `c_out` = 1 iff acc ≥ operand (unsigned).
- `ovf` is computed from the pre-update acc `a`, the operand `b` and the result `r`:
  - ADD: (a[31] == b[31]) && (r[31] != a[31]).
  - SUB: (a[31] != b[31]) && (r[31] != a[31]).
- LOAD and CLEAR force `c_out` = 0 and `ovf` = 0.
- `zero` is recomputed for every command from the new acc value.
- Commands presented while not in IDLE are not accepted. Upstream must hold `in_valid`, `op` and `operand` until accepted.
- A reset sampled in any state forces IDLE on the next edge. Any in-flight command is discarded and no response is produced.

## Timing
- Reset values: state IDLE, `acc` = ACC_INIT, `c_out` = 0, `ovf` = 0, `zero` = (ACC_INIT == 0), `ovf_sticky` = 0, `out_valid` = 0.
- `in_ready` is 1 in the first cycle with `rst_n` = 1.
- Command latency: accept at edge T, EXEC during cycle T+1, `out_valid` high from T+2.
- Minimum initiation interval is 3 cycles: accept, EXEC, then RESP with `out_ready` = 1.
- `in_ready` is 0 from the cycle after acceptance until the cycle after the response handshake.
- `out_valid` stays high with stable data for any number of cycles while `out_ready` = 0.
- `in_valid` and `out_ready` may both be high in RESP. The response completes first; a new command is accepted no earlier than the following cycle (IDLE).
- The adder path is purely combinational within EXEC. No output is driven combinationally from `operand` or `op`.

## Configuration
- Macro `RCAS_ACC_STICKY_EN`.
- Defined:
  - `ovf_sticky` is registered. It is set on any EXEC with `ovf` = 1.
  - It is cleared by CLEAR and by reset; LOAD does not clear it.
- Undefined: `ovf_sticky` is tied to 0 and no register is built. The port remains present.

## Test plan
- **Reset:** hold `rst_n` = 0 for 2 cycles with ACC_INIT = 32'h0000_0010, then release. Expect `acc` = 32'h10, `zero` = 0, `out_valid` = 0, and `in_ready` = 1 in the first released cycle.
- **Basic sequence:** LOAD 5, ADD 3, SUB 8. Expect `acc` = 5, 8, 0 in the respective responses. The last response has `zero` = 1 and `c_out` = 1, and each `out_valid` rises 2 cycles after acceptance.
- **Overflow and borrow:**
  - LOAD 32'h7FFF_FFFF, then ADD 1. Expect 32'h8000_0000, `ovf` = 1, `c_out` = 0.
  - LOAD 3, then SUB 5. Expect 32'hFFFF_FFFE, `c_out` = 0, `ovf` = 0.
- **Backpressure:** ADD 1 with `out_ready` low for 5 cycles. Expect `out_valid` and `acc` stable, `in_ready` = 0, and a held `in_valid` not accepted until after the handshake.
- **Reset mid-operation:** assert `rst_n` = 0 during EXEC of ADD 7 from acc = 1. Expect `acc` = ACC_INIT and no `out_valid` pulse.
- **Sticky flag** (with `RCAS_ACC_STICKY_EN`): overflowing ADD, then ADD 0. Expect `ovf` = 0 and `ovf_sticky` = 1; a subsequent CLEAR gives 0. Without the macro, `ovf_sticky` stays 0 throughout.

Source files
------------

// File: rtl/rcas_acc_32bit.sv
// rcas_acc_32bit: handshaked accumulator built on a 32-bit ripple-carry
// adder/subtractor (rcas_32bit, included in this file).
// Commands: LOAD, ADD, SUB, CLEAR. Each command passes through IDLE -> EXEC -> RESP.
// Optional feature macro: RCAS_ACC_STICKY_EN builds the sticky overflow register.
// When the macro is not defined, ovf_sticky is tied to 0.

module rcas_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sel,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c_out
);

    // Bit-serial ripple chain; sel inverts b so that sel=1 with c_in=1 gives a - b
    always_comb begin : ripple_chain
        logic carry_v;
        logic b_bit_v;
        carry_v = c_in;
        b_bit_v = 1'b0;
        sum     = 32'h0000_0000;
        for (int i = 0; i < 32; i++) begin
            b_bit_v = b[i] ^ sel;
            sum[i]  = a[i] ^ b_bit_v ^ carry_v;
            carry_v = (a[i] & b_bit_v) | (carry_v & (a[i] ^ b_bit_v));
        end
        c_out = carry_v;
    end

endmodule

module rcas_acc_32bit #(
    parameter logic [31:0] ACC_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] operand,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] acc,
    output logic        c_out,
    output logic        ovf,
    output logic        zero,
    output logic        ovf_sticky
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t      state_r;
    logic [1:0]  op_r;
    logic [31:0] operand_r;
    logic [31:0] acc_r;
    logic        c_out_r;
    logic        ovf_r;
    logic        zero_r;
    logic        out_valid_r;

    logic        sub_s;
    logic [31:0] sum_s;
    logic        carry_s;
    logic [31:0] acc_next_s;
    logic        c_next_s;
    logic        ovf_next_s;

    // Signed overflow from operand and result sign bits. For subtraction, the
    // operands must differ in sign for the result to overflow.
    function automatic logic calc_ovf(input logic is_sub, input logic a_msb,
                                      input logic b_msb, input logic r_msb);
        logic res_v;
        if (is_sub) begin
            res_v = (a_msb != b_msb) && (r_msb != a_msb);
        end else begin
            res_v = (a_msb == b_msb) && (r_msb != a_msb);
        end
        return res_v;
    endfunction

    assign sub_s = (op_r == OP_SUB);

    rcas_32bit u_rcas (
        .a     (acc_r),
        .b     (operand_r),
        .sel   (sub_s),
        .c_in  (sub_s),
        .sum   (sum_s),
        .c_out (carry_s)
    );

    // Select the new accumulator value and flags for the latched command
    always_comb begin
        acc_next_s = acc_r;
        c_next_s   = 1'b0;
        ovf_next_s = 1'b0;
        case (op_r)
            OP_LOAD: begin
                acc_next_s = operand_r;
            end
            OP_ADD, OP_SUB: begin
                acc_next_s = sum_s;
                c_next_s   = carry_s;
                ovf_next_s = calc_ovf(sub_s, acc_r[31], operand_r[31], sum_s[31]);
            end
            OP_CLEAR: begin
                acc_next_s = 32'h0000_0000;
            end
            default: begin
                acc_next_s = acc_r;
            end
        endcase
    end

    // Control FSM: command latch, accumulator/flag update and response handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_LOAD;
            operand_r   <= 32'h0000_0000;
            acc_r       <= ACC_INIT;
            c_out_r     <= 1'b0;
            ovf_r       <= 1'b0;
            zero_r      <= (ACC_INIT == 32'h0000_0000);
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_r      <= op;
                        operand_r <= operand;
                        state_r   <= ST_EXEC;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    acc_r       <= acc_next_s;
                    c_out_r     <= c_next_s;
                    ovf_r       <= ovf_next_s;
                    zero_r      <= (acc_next_s == 32'h0000_0000);
                    out_valid_r <= 1'b1;
                    state_r     <= ST_RESP;
                end
                ST_RESP: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_RESP;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RCAS_ACC_STICKY_EN
    logic ovf_sticky_r;

    // Sticky overflow: set by any overflowing EXEC, cleared only by CLEAR or reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_sticky_r <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            if (op_r == OP_CLEAR) begin
                ovf_sticky_r <= 1'b0;
            end else begin
                ovf_sticky_r <= ovf_sticky_r | ovf_next_s;
            end
        end else begin
            ovf_sticky_r <= ovf_sticky_r;
        end
    end

    assign ovf_sticky = ovf_sticky_r;
`else
    assign ovf_sticky = 1'b0;
`endif

    // in_ready is forced low while reset is asserted
    assign in_ready  = (state_r == ST_IDLE) & rst_n;
    assign out_valid = out_valid_r;
    assign acc       = acc_r;
    assign c_out     = c_out_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_rcas_acc_32bit.sv
// Directed testbench for rcas_acc_32bit with ACC_INIT = 32'h10.
// Inputs are driven and outputs are sampled on the falling edge.
module tb_rcas_acc_32bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] operand;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] acc;
    logic        c_out;
    logic        ovf;
    logic        zero;
    logic        ovf_sticky;

    int checks = 0;
    int errors = 0;

`ifdef RCAS_ACC_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    localparam logic [1:0] LOAD  = 2'b00;
    localparam logic [1:0] ADD   = 2'b01;
    localparam logic [1:0] SUB   = 2'b10;
    localparam logic [1:0] CLEAR = 2'b11;

    rcas_acc_32bit #(.ACC_INIT(32'h0000_0010)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .operand    (operand),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .acc        (acc),
        .c_out      (c_out),
        .ovf        (ovf),
        .zero       (zero),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one command from IDLE with out_ready high. The task starts and ends on a falling edge.
    task automatic do_cmd(input string tag, input logic [1:0] c_op, input logic [31:0] c_operand,
                          input logic [31:0] e_acc, input logic e_c, input logic e_ovf,
                          input logic e_zero, input logic e_sticky);
        in_valid = 1'b1;
        op       = c_op;
        operand  = c_operand;
        #1;
        chk({tag, ".in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        operand  = 32'hA5A5_A5A5;
        chk({tag, ".out_valid_exec"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".in_ready_exec"}, {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk({tag, ".out_valid_resp"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".acc"}, acc, e_acc);
        chk({tag, ".c_out"}, {31'd0, c_out}, {31'd0, e_c});
        chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, e_ovf});
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, e_zero});
        chk({tag, ".sticky"}, {31'd0, ovf_sticky}, {31'd0, e_sticky});
        @(negedge clk);
        chk({tag, ".out_valid_done"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = LOAD;
        operand   = 32'h0000_0000;
        out_ready = 1'b1;

        // Reset held for two rising edges
        @(negedge clk);
        chk("rst.in_ready_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.acc", acc, 32'h0000_0010);
        chk("rst.zero", {31'd0, zero}, 32'd0);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.c_out", {31'd0, c_out}, 32'd0);
        chk("rst.ovf", {31'd0, ovf}, 32'd0);
        chk("rst.sticky", {31'd0, ovf_sticky}, 32'd0);
        @(negedge clk);

        // Basic sequence
        do_cmd("load5", LOAD, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        do_cmd("add3",  ADD,  32'd3, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        do_cmd("sub8",  SUB,  32'd8, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Signed overflow on ADD, then a non-overflowing ADD keeps the sticky flag
        do_cmd("load_max", LOAD, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        do_cmd("add_ovf",  ADD,  32'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, STICKY);
        do_cmd("add0",     ADD,  32'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0, STICKY);

        // Borrow; LOAD does not clear the sticky flag
        do_cmd("load3",  LOAD, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0, STICKY);
        do_cmd("sub5",   SUB,  32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, STICKY);
        do_cmd("clear1", CLEAR, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Signed overflow on SUB without a borrow
        do_cmd("load_min", LOAD, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        do_cmd("sub_ovf",  SUB,  32'd1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, STICKY);
        do_cmd("load0",    LOAD, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, STICKY);
        do_cmd("clear2",   CLEAR, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Backpressure: ADD 1 from 0 with out_ready held low, next command waiting
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = ADD;
        operand   = 32'd1;
        @(negedge clk);
        operand   = 32'd100;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp.out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp.acc", acc, 32'd1);
            chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp.released_valid", {31'd0, out_valid}, 32'd0);
        chk("bp.not_yet_accepted", acc, 32'd1);
        chk("bp.in_ready_idle", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp.held_exec", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("bp.held_resp_valid", {31'd0, out_valid}, 32'd1);
        chk("bp.held_resp_acc", acc, 32'd101);
        @(negedge clk);

        // Reset during EXEC of ADD 7 from acc = 1
        do_cmd("load1", LOAD, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        op       = ADD;
        operand  = 32'd7;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        chk("midrst.acc", acc, 32'h0000_0010);
        chk("midrst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst.in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst.no_resp", {31'd0, out_valid}, 32'd0);
        chk("midrst.acc_after", acc, 32'h0000_0010);
        chk("midrst.in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("midrst.zero", {31'd0, zero}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
